// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory bank port.
// FSM states, trace entry layout and the byte-lane merge.
package dm_pkg;

  localparam int BYTEEN_W = 4;

  typedef enum logic [1:0] {
    CLR,
    IDLE,
    WAIT
  } dm_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } dm_trace_t;

  localparam int TRACE_W = $bits(dm_trace_t);

  function automatic logic [31:0] byte_merge(
    input logic [31:0]         old_w,
    input logic [31:0]         new_w,
    input logic [BYTEEN_W-1:0] be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < BYTEEN_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_trace_fifo.sv
// Synchronous FIFO for write-trace entries.
// A push into a full FIFO survives only if a pop frees a slot that cycle.
module dm_trace_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [PW:0]   cnt_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign dout    = empty ? '0 : mem_q[rp_q];

  // Pointers and occupancy; both sides may move in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + PTR_ONE;
      if (pop_ok)  rp_q <= rp_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care while a slot is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/dm_bank_port.sv
// Handshaked data-memory bank with wait states, address window,
// byte-enable merge, post-reset clear sweep and write-trace FIFO.
module dm_bank_port
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 0,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [BYTEEN_W-1:0] req_byteen,
  input  logic [31:0]         req_wdata,
  input  logic [31:0]         req_pc,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                trc_valid,
  input  logic                trc_ready,
  output logic [31:0]         trc_pc,
  output logic [31:0]         trc_addr,
  output logic [31:0]         trc_data,
  output logic                trc_overflow
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT  = 4'(LATENCY);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
  localparam logic [AW-1:0] IDX_ONE  = 1;

  dm_state_e     state_q;
  dm_state_e     state_d;
  logic [AW-1:0] clr_q;
  logic [3:0]    cnt_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic          in_win;
  logic [AW-1:0] widx;
  logic [31:0]   old_w;
  logic [31:0]   merged;
  logic          acc;
  logic          acc_wr;
  logic          acc_rd;

  dm_trace_t     trc_in;
  dm_trace_t     trc_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;

  assign off    = req_addr - BASE_ADDR;
  assign in_win = (off < SPAN);
  assign widx   = off[AW+1:2];
  assign old_w  = mem[widx];
  assign merged = byte_merge(old_w, req_wdata, req_byteen);
  assign acc    = reset & req_valid & req_ready;
  assign acc_wr = acc & in_win & (|req_byteen);
  assign acc_rd = acc & in_win & ~(|req_byteen);

  // Next state and ready decode from the registered state only.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    unique case (state_q)
      CLR: begin
        if (clr_q == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = WAIT;
      end
      WAIT: begin
        if (rsp_valid) state_d = IDLE;
      end
      default: state_d = CLR;
    endcase
  end

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= CLR;
    else        state_q <= state_d;
  end

  // Sweep index walks one word per cycle while clearing.
  always_ff @(posedge clk) begin
    if (!reset)              clr_q <= '0;
    else if (state_q == CLR) clr_q <= clr_q + IDX_ONE;
  end

  // Response path: data captured at accept, pulse after the wait count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (acc) begin
      cnt_q     <= LAT;
      rsp_valid <= (LAT == 4'd0);
      rsp_err   <= ~in_win;
      rsp_rdata <= acc_rd ? old_w : '0;
    end else if (state_q == WAIT) begin
      if (rsp_valid) begin
        rsp_valid <= 1'b0;
      end else begin
        cnt_q     <= cnt_q - 4'd1;
        rsp_valid <= (cnt_q == 4'd1);
      end
    end
  end

  // Word array: zeroed by the sweep, merged-written on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == CLR) mem[clr_q] <= '0;
      else if (acc_wr)    mem[widx]  <= merged;
    end
  end

  assign trc_in = '{
    pc:   req_pc,
    addr: {req_addr[31:2], 2'b00},
    data: merged
  };

  dm_trace_fifo #(
    .W     (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk   (clk),
    .reset (reset),
    .push  (acc_wr),
    .din   (trc_in),
    .pop   (trc_ready),
    .dout  (trc_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign trc_valid = ~fifo_empty;
  assign trc_pc    = trc_head.pc;
  assign trc_addr  = trc_head.addr;
  assign trc_data  = trc_head.data;

  // Sticky flag set whenever a trace push is lost.
  always_ff @(posedge clk) begin
    if (!reset)         trc_overflow <= 1'b0;
    else if (fifo_drop) trc_overflow <= 1'b1;
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_dm_bank_port.sv
// Directed bench for dm_bank_port: clear sweep, merge, wait states,
// window errors, trace overflow and reset during a pending response.
module tb_dm_bank_port;

  localparam int unsigned DW  = 16;
  localparam logic [31:0] BA  = 32'h0000_1000;
  localparam int unsigned LAT = 3;
  localparam int unsigned TD  = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_pc;
  logic [31:0] trc_addr;
  logic [31:0] trc_data;
  logic        trc_overflow;

  int errors;
  int checks;

  dm_bank_port #(
    .DEPTH_WORDS (DW),
    .BASE_ADDR   (BA),
    .LATENCY     (LAT),
    .TRACE_DEPTH (TD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_byteen   (req_byteen),
    .req_wdata    (req_wdata),
    .req_pc       (req_pc),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .trc_valid    (trc_valid),
    .trc_ready    (trc_ready),
    .trc_pc       (trc_pc),
    .trc_addr     (trc_addr),
    .trc_data     (trc_data),
    .trc_overflow (trc_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(
    input logic [31:0] a,
    input logic [3:0]  be,
    input logic [31:0] wd,
    input logic [31:0] pc,
    input logic        pop
  );
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout got=%0b want=1", req_ready);
    end
    req_valid  = 1'b1;
    req_addr   = a;
    req_byteen = be;
    req_wdata  = wd;
    req_pc     = pc;
    trc_ready  = pop;
    step();
    req_valid  = 1'b0;
    req_byteen = 4'h0;
    trc_ready  = 1'b0;
  endtask

  task automatic wait_rsp(
    output int          lat,
    output logic [31:0] d,
    output logic        e
  );
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      step();
      lat++;
    end
    d = rsp_rdata;
    e = rsp_err;
  endtask

  task automatic pop_one();
    trc_ready = 1'b1;
    step();
    trc_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_ready got=%0b want=0", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL rst_rsp got=%0b/%0b/%h want=0/0/0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if ({trc_valid, trc_overflow} !== 2'b00) begin
      errors++;
      $display("FAIL rst_trc_flags got=%0b%0b want=00",
               trc_valid, trc_overflow);
    end
    checks++;
    if ({trc_pc, trc_addr, trc_data} !== 96'h0) begin
      errors++;
      $display("FAIL rst_trc_fields got=%h %h %h want=0",
               trc_pc, trc_addr, trc_data);
    end
  endtask

  task automatic test_clear();
    int n;
    int lat;
    logic [31:0] d;
    logic e;
    reset = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clr_ready_cycle got=%0d want=16", n);
    end
    do_req(32'h0000_1008, 4'h0, 32'h0, 32'h100, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (lat != 4 || d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL clr_read got=%0d/%h/%0b want=4/00000000/0",
               lat, d, e);
    end
  endtask

  task automatic test_byte_merge();
    int lat;
    logic [31:0] d;
    logic e;
    do_req(32'h0000_1010, 4'hF, 32'h1122_3344, 32'h400, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL merge_wr_rsp got=%h/%0b want=00000000/0", d, e);
    end
    do_req(32'h0000_1012, 4'b0101, 32'hAABB_CCDD, 32'h404, 1'b0);
    wait_rsp(lat, d, e);
    do_req(32'h0000_1010, 4'h0, 32'h0, 32'h408, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (d !== 32'h11BB_33DD || e !== 1'b0) begin
      errors++;
      $display("FAIL merge_read got=%h/%0b want=11bb33dd/0", d, e);
    end
    checks++;
    if (trc_valid !== 1'b1 || trc_pc !== 32'h400 ||
        trc_addr !== 32'h1010 || trc_data !== 32'h1122_3344) begin
      errors++;
      $display("FAIL merge_trc0 got=%0b %h %h %h want=1 400 1010 11223344",
               trc_valid, trc_pc, trc_addr, trc_data);
    end
    pop_one();
    checks++;
    if (trc_valid !== 1'b1 || trc_pc !== 32'h404 ||
        trc_addr !== 32'h1010 || trc_data !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL merge_trc1 got=%0b %h %h %h want=1 404 1010 11bb33dd",
               trc_valid, trc_pc, trc_addr, trc_data);
    end
    pop_one();
    checks++;
    if (trc_valid !== 1'b0 || trc_overflow !== 1'b0) begin
      errors++;
      $display("FAIL merge_trc_empty got=%0b%0b want=00",
               trc_valid, trc_overflow);
    end
  endtask

  task automatic test_wait_states();
    int n;
    int lat;
    logic [31:0] d;
    logic e;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    req_valid  = 1'b1;
    req_addr   = 32'h0000_1020;
    req_byteen = 4'hF;
    req_wdata  = 32'hCAFE_F00D;
    req_pc     = 32'h500;
    #1;
    checks++;
    if (req_ready !== 1'b1 || trc_valid !== 1'b0) begin
      errors++;
      $display("FAIL ws_pre_accept got=%0b%0b want=10",
               req_ready, trc_valid);
    end
    step();
    req_valid  = 1'b0;
    req_byteen = 4'h0;
    checks++;
    if (trc_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ws_post_accept got=%0b%0b want=10",
               trc_valid, req_ready);
    end
    wait_rsp(lat, d, e);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL ws_latency got=%0d want=4", lat);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ws_ready_with_rsp got=%0b want=0", req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ws_after_rsp got=%0b%0b want=01",
               rsp_valid, req_ready);
    end
    checks++;
    if (trc_pc !== 32'h500 || trc_addr !== 32'h1020 ||
        trc_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL ws_trc got=%h %h %h want=500 1020 cafef00d",
               trc_pc, trc_addr, trc_data);
    end
    pop_one();
  endtask

  task automatic test_window_error();
    int lat;
    logic [31:0] d;
    logic e;
    do_req(32'h0000_1040, 4'hF, 32'hFFFF_FFFF, 32'h580, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0 || lat != 4) begin
      errors++;
      $display("FAIL win_hi got=%0b/%h/%0d want=1/00000000/4", e, d, lat);
    end
    checks++;
    if (trc_valid !== 1'b0) begin
      errors++;
      $display("FAIL win_no_trace got=%0b want=0", trc_valid);
    end
    do_req(32'h0000_0FFC, 4'h0, 32'h0, 32'h584, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL win_lo got=%0b/%h want=1/00000000", e, d);
    end
    do_req(32'h0000_1000, 4'h0, 32'h0, 32'h588, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (e !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL win_base_unchanged got=%0b/%h want=0/00000000", e, d);
    end
    do_req(32'h0000_103C, 4'h0, 32'h0, 32'h58C, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (e !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL win_top_word got=%0b/%h want=0/00000000", e, d);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] d;
    logic e;
    do_req(32'h0000_1004, 4'hF, 32'h1, 32'h600, 1'b0);
    wait_rsp(lat, d, e);
    do_req(32'h0000_1008, 4'hF, 32'h2, 32'h604, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (trc_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_full got=%0b want=0", trc_overflow);
    end
    do_req(32'h0000_100C, 4'hF, 32'h3, 32'h608, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (trc_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got=%0b want=1", trc_overflow);
    end
    checks++;
    if (trc_pc !== 32'h600 || trc_data !== 32'h1) begin
      errors++;
      $display("FAIL ovf_head got=%h/%h want=600/00000001",
               trc_pc, trc_data);
    end
    do_req(32'h0000_1014, 4'hF, 32'h4, 32'h60C, 1'b1);
    checks++;
    if (trc_valid !== 1'b1 || trc_pc !== 32'h604 || trc_data !== 32'h2) begin
      errors++;
      $display("FAIL ovf_pushpop_head got=%0b %h/%h want=1 604/00000002",
               trc_valid, trc_pc, trc_data);
    end
    wait_rsp(lat, d, e);
    pop_one();
    checks++;
    if (trc_valid !== 1'b1 || trc_pc !== 32'h60C ||
        trc_addr !== 32'h1014 || trc_data !== 32'h4) begin
      errors++;
      $display("FAIL ovf_pushpop_tail got=%0b %h %h %h want=1 60c 1014 4",
               trc_valid, trc_pc, trc_addr, trc_data);
    end
    pop_one();
    checks++;
    if (trc_valid !== 1'b0 || trc_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained got=%0b%0b want=01",
               trc_valid, trc_overflow);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int lat;
    logic seen;
    logic [31:0] d;
    logic e;
    do_req(32'h0000_1018, 4'hF, 32'h7777_8888, 32'h700, 1'b0);
    seen = rsp_valid;
    step();
    seen = seen | rsp_valid;
    reset = 1'b0;
    step();
    seen = seen | rsp_valid;
    checks++;
    if (req_ready !== 1'b0 || trc_valid !== 1'b0 ||
        trc_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rmw_after_reset got=%0b%0b%0b want=000",
               req_ready, trc_valid, trc_overflow);
    end
    reset = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      seen = seen | rsp_valid;
      step();
      n++;
    end
    seen = seen | rsp_valid;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rmw_no_rsp got=%0b want=0", seen);
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL rmw_sweep_restart got=%0d want=16", n);
    end
    checks++;
    if (trc_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmw_fifo_empty got=%0b want=0", trc_valid);
    end
    do_req(32'h0000_1018, 4'h0, 32'h0, 32'h704, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL rmw_cleared_1018 got=%h/%0b/%0d want=0/0/4", d, e, lat);
    end
    do_req(32'h0000_1010, 4'h0, 32'h0, 32'h708, 1'b0);
    wait_rsp(lat, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rmw_cleared_1010 got=%h want=00000000", d);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_byteen = 4'h0;
    req_wdata  = 32'h0;
    req_pc     = 32'h0;
    trc_ready  = 1'b0;
    test_reset();
    test_clear();
    test_byte_merge();
    test_wait_states();
    test_window_error();
    test_overflow();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
